// File: rtl/bcd_seg_scanner_if.sv
// Display-side bundle for bcd_seg_scanner: BCD load port, blanking control and the 7-segment drive.
// The optional decimal-point lanes exist only when BCD_SCAN_DP_EN is defined.
interface bcd_seg_scanner_if;
   logic [15:0] bcd_in;
   logic        bcd_valid;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        frame_done;
`ifdef BCD_SCAN_DP_EN
   logic [3:0]  dp_in;
   logic        dp;

   modport master (output bcd_in, bcd_valid, blank_lz, dp_in,
                   input  seg, dig_en, frame_done, dp);
   modport slave  (input  bcd_in, bcd_valid, blank_lz, dp_in,
                   output seg, dig_en, frame_done, dp);
`else
   modport master (output bcd_in, bcd_valid, blank_lz,
                   input  seg, dig_en, frame_done);
   modport slave  (input  bcd_in, bcd_valid, blank_lz,
                   output seg, dig_en, frame_done);
`endif
endinterface

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with frame-aligned double buffering,
// per-slot dead time and leading-zero blanking. Optional decimal points: BCD_SCAN_DP_EN.
module bcd_seg_scanner #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned GUARD    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   bcd_seg_scanner_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [15:0]      r_pend;
   logic             r_pend_vld;
   logic [15:0]      r_disp;
   logic [6:0]       r_seg;
   logic [3:0]       r_dig_en;
   logic             r_frame_done;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_idx_nxt;
   logic [15:0]      w_pend_nxt;
   logic             w_pend_vld_nxt;
   logic [15:0]      w_disp_nxt;
   logic [6:0]       w_seg_nxt;
   logic [3:0]       w_dig_en_nxt;
   logic             w_cnt_last;
   logic             w_boundary;
   logic             w_active;
   logic             w_blank;
   logic             w_upper_zero;
   logic [3:0]       w_nib;
   logic [3:0]       w_shamt;
   logic             w_dp_bit;

`ifdef BCD_SCAN_DP_EN
   logic [3:0] r_pend_dp;
   logic [3:0] r_disp_dp;
   logic       r_dp;
   logic [3:0] w_pend_dp_nxt;
   logic [3:0] w_disp_dp_nxt;
   logic       w_dp_nxt;
`endif

   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Next-state for scan position and buffers; outputs derive from the next position.
   always_comb begin
      w_cnt_last     = (r_cnt == CNT_W'(SCAN_DIV - 1));
      w_boundary     = w_cnt_last && (r_idx == 2'd3);
      w_cnt_nxt      = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      w_idx_nxt      = w_cnt_last ? r_idx + 2'd1 : r_idx;
      w_disp_nxt     = (w_boundary && r_pend_vld) ? r_pend : r_disp;
      w_pend_nxt     = bus.bcd_valid ? bus.bcd_in : r_pend;
      w_pend_vld_nxt = bus.bcd_valid | (r_pend_vld & ~w_boundary);

      w_shamt      = {w_idx_nxt, 2'b00};
      w_nib        = w_disp_nxt[w_shamt +: 4];
      w_upper_zero = ((w_disp_nxt >> w_shamt) == 16'd0);
`ifdef BCD_SCAN_DP_EN
      w_pend_dp_nxt = bus.bcd_valid ? bus.dp_in : r_pend_dp;
      w_disp_dp_nxt = (w_boundary && r_pend_vld) ? r_pend_dp : r_disp_dp;
      w_dp_bit      = w_disp_dp_nxt[w_idx_nxt];
`else
      w_dp_bit      = 1'b0;
`endif
      w_active = (32'(w_cnt_nxt) >= GUARD);
      w_blank  = bus.blank_lz && (w_idx_nxt != 2'd0) && w_upper_zero && !w_dp_bit;

      w_dig_en_nxt = w_active ? (4'b0001 << w_idx_nxt) : 4'b0000;
      w_seg_nxt    = (w_active && !w_blank) ? seg_encode(w_nib) : 7'h00;
`ifdef BCD_SCAN_DP_EN
      w_dp_nxt     = w_active && w_dp_bit;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt        <= '0;
         r_idx        <= 2'd0;
         r_pend       <= 16'd0;
         r_pend_vld   <= 1'b0;
         r_disp       <= 16'd0;
         r_seg        <= 7'h00;
         r_dig_en     <= 4'b0000;
         r_frame_done <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_vld   <= w_pend_vld_nxt;
         r_disp       <= w_disp_nxt;
         r_seg        <= w_seg_nxt;
         r_dig_en     <= w_dig_en_nxt;
         r_frame_done <= w_boundary;
      end
   end

`ifdef BCD_SCAN_DP_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pend_dp <= 4'd0;
         r_disp_dp <= 4'd0;
         r_dp      <= 1'b0;
      end else begin
         r_pend_dp <= w_pend_dp_nxt;
         r_disp_dp <= w_disp_dp_nxt;
         r_dp      <= w_dp_nxt;
      end
   end

   assign bus.dp = r_dp;
`endif

   assign bus.seg        = r_seg;
   assign bus.dig_en     = r_dig_en;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (SCAN_DIV=8, GUARD=2): a cycle-position
// reference model plus directed display patterns and randomized load traffic.
module tb_bcd_seg_scanner;

   localparam int unsigned SD    = 8;
   localparam int unsigned GD    = 2;
   localparam int unsigned FRAME = 4 * SD;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bcd_seg_scanner_if bus();

   bcd_seg_scanner #(.SCAN_DIV(SD), .GUARD(GD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: position = cycles since reset release; buffers as plain values.
   int          pos = 0;
   logic [15:0] m_disp = 16'd0;
   logic [15:0] m_pend = 16'd0;
   bit          m_pvld = 1'b0;
   logic        exp_fd = 1'b0;
   logic [3:0]  exp_dig = 4'd0;
   logic [6:0]  exp_seg = 7'd0;

   logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   logic [15:0] pat_val   [4] = '{16'h0050, 16'h0000, 16'h0000, 16'hA9F0};
   logic        pat_blank [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [6:0]  pat_want  [4][4] = '{'{7'h3F, 7'h6D, 7'h00, 7'h00},
                                     '{7'h3F, 7'h00, 7'h00, 7'h00},
                                     '{7'h3F, 7'h3F, 7'h3F, 7'h3F},
                                     '{7'h3F, 7'h40, 7'h6F, 7'h40}};

   // Advance one clock, update the model from the inputs the DUT sampled, settle.
   task automatic step();
      bit          bnd;
      int          slot;
      logic [15:0] sh;
      @(posedge clk);
      if (!reset_n) begin
         pos = 0; m_disp = 16'd0; m_pend = 16'd0; m_pvld = 1'b0;
         exp_fd = 1'b0; exp_dig = 4'd0; exp_seg = 7'd0;
      end else begin
         bnd = ((pos % FRAME) == FRAME - 1);
         pos++;
         exp_fd = bnd;
         if (bnd && m_pvld) begin m_disp = m_pend; m_pvld = 1'b0; end
         if (bus.bcd_valid) begin m_pend = bus.bcd_in; m_pvld = 1'b1; end
         slot = (pos / SD) % 4;
         sh   = m_disp >> (4 * slot);
         if ((pos % SD) < GD) begin
            exp_dig = 4'd0;
            exp_seg = 7'd0;
         end else begin
            exp_dig = 4'(1 << slot);
            exp_seg = (bus.blank_lz && slot != 0 && sh == 16'd0) ? 7'd0 : seg_lut[sh[3:0]];
         end
      end
      #1;
   endtask

   task automatic strobe(input logic [15:0] v);
      bus.bcd_in    = v;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      bus.bcd_in    = 16'($urandom);
   endtask

   task automatic advance_to(input int target);
      for (int k = 0; k < 2 * FRAME; k++) begin
         if ((pos % FRAME) == target) break;
         step();
      end
   endtask

   task automatic test_reset();
      int first_fd;
      int second_fd;
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (bus.seg !== 7'h00) begin failures++; $display("FAIL reset_seg got=%h want=00", bus.seg); end
         checks++; if (bus.dig_en !== 4'b0000) begin failures++; $display("FAIL reset_dig got=%b want=0000", bus.dig_en); end
         checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
      end
      reset_n = 1'b1;
      step();
      checks++; if (bus.dig_en !== 4'b0000) begin failures++; $display("FAIL rel_cnt1 got=%b want=0000", bus.dig_en); end
      step();
      checks++; if (bus.dig_en !== 4'b0001) begin failures++; $display("FAIL rel_cnt2 got=%b want=0001", bus.dig_en); end
      repeat (SD) step();
      checks++; if (bus.dig_en !== 4'b0010) begin failures++; $display("FAIL slot1_cnt2 got=%b want=0010", bus.dig_en); end
      first_fd = -1; second_fd = -1;
      for (int c = 0; c < 3 * FRAME; c++) begin
         step();
         checks++; if (bus.frame_done !== exp_fd) begin failures++; $display("FAIL fd_model pos=%0d got=%b want=%b", pos, bus.frame_done, exp_fd); end
         if (bus.frame_done === 1'b1) begin
            if (first_fd < 0) first_fd = pos;
            else if (second_fd < 0) second_fd = pos;
         end
      end
      checks++; if (first_fd != FRAME) begin failures++; $display("FAIL fd_first got=%0d want=%0d", first_fd, FRAME); end
      checks++; if (second_fd - first_fd != FRAME) begin failures++; $display("FAIL fd_period got=%0d want=%0d", second_fd - first_fd, FRAME); end
   endtask

   task automatic test_load_mid_frame();
      logic [6:0] want [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
      bus.blank_lz = 1'b0;
      advance_to(12);
      strobe(16'h1234);
      while ((pos % FRAME) != 0) begin
         step();
         checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL hold_old pos=%0d got=%h want=%h", pos, bus.seg, exp_seg); end
      end
      checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL switch_fd got=%b want=1", bus.frame_done); end
      for (int c = 0; c < FRAME; c++) begin
         if (c != 0) step();
         checks++; if (bus.dig_en !== exp_dig) begin failures++; $display("FAIL l1234_dig pos=%0d got=%b want=%b", pos, bus.dig_en, exp_dig); end
         if (exp_dig != 4'd0) begin
            checks++; if (bus.seg !== want[(pos / SD) % 4]) begin failures++; $display("FAIL l1234_seg pos=%0d got=%h want=%h", pos, bus.seg, want[(pos / SD) % 4]); end
         end
      end
   endtask

   task automatic test_patterns();
      for (int r = 0; r < 4; r++) begin
         bus.blank_lz = pat_blank[r];
         advance_to(10);
         strobe(pat_val[r]);
         advance_to(0);
         for (int c = 0; c < FRAME; c++) begin
            if (c != 0) step();
            checks++; if (bus.dig_en !== exp_dig) begin failures++; $display("FAIL pat%0d_dig pos=%0d got=%b want=%b", r, pos, bus.dig_en, exp_dig); end
            checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL pat%0d_model pos=%0d got=%h want=%h", r, pos, bus.seg, exp_seg); end
            if (exp_dig != 4'd0) begin
               checks++; if (bus.seg !== pat_want[r][(pos / SD) % 4]) begin failures++; $display("FAIL pat%0d_seg pos=%0d got=%h want=%h", r, pos, bus.seg, pat_want[r][(pos / SD) % 4]); end
            end
         end
      end
      bus.blank_lz = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [6:0] want [3] = '{7'h5B, 7'h66, 7'h4F};
      bus.blank_lz = 1'b0;
      advance_to(5);
      strobe(16'h1111);
      advance_to(10);
      strobe(16'h2222);
      advance_to(0);
      for (int f = 0; f < 3; f++) begin
         if (f == 1) begin
            advance_to(6);
            strobe(16'h4444);
         end
         if (f >= 1) begin
            advance_to(FRAME - 1);
            if (f == 1) strobe(16'h3333);
            else step();
         end
         checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL b2b%0d_fd got=%b want=1", f, bus.frame_done); end
         for (int c = 0; c < FRAME - 1; c++) begin
            if (c != 0) step();
            if (exp_dig != 4'd0) begin
               checks++; if (bus.seg !== want[f]) begin failures++; $display("FAIL b2b%0d_seg pos=%0d got=%h want=%h", f, pos, bus.seg, want[f]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bus.blank_lz = 1'b0;
      advance_to(3);
      strobe(16'h5678);
      advance_to(20);
      reset_n = 1'b0;
      step();
      step();
      checks++; if (bus.dig_en !== 4'b0000) begin failures++; $display("FAIL rst_mid_dig got=%b want=0000", bus.dig_en); end
      reset_n = 1'b1;
      for (int c = 0; c < 2 * FRAME + 4; c++) begin
         step();
         checks++; if (bus.dig_en !== exp_dig) begin failures++; $display("FAIL rst_mid_model pos=%0d got=%b want=%b", pos, bus.dig_en, exp_dig); end
         if (exp_dig != 4'd0) begin
            checks++; if (bus.seg !== 7'h3F) begin failures++; $display("FAIL rst_mid_seg pos=%0d got=%h want=3f", pos, bus.seg); end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 20 * FRAME; c++) begin
         bus.bcd_valid = ($urandom_range(0, 11) == 0);
         bus.bcd_in    = 16'($urandom);
         if ($urandom_range(0, 3) == 0) bus.bcd_in[15:8] = 8'h00;
         if ($urandom_range(0, 40) == 0) bus.blank_lz = ~bus.blank_lz;
         step();
         checks++; if (bus.dig_en !== exp_dig) begin failures++; $display("FAIL rnd_dig pos=%0d got=%b want=%b", pos, bus.dig_en, exp_dig); end
         checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL rnd_seg pos=%0d got=%h want=%h", pos, bus.seg, exp_seg); end
         checks++; if (bus.frame_done !== exp_fd) begin failures++; $display("FAIL rnd_fd pos=%0d got=%b want=%b", pos, bus.frame_done, exp_fd); end
      end
      bus.bcd_valid = 1'b0;
   endtask

   initial begin
      bus.bcd_in    = 16'd0;
      bus.bcd_valid = 1'b0;
      bus.blank_lz  = 1'b0;
      test_reset();
      test_load_mid_frame();
      test_patterns();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
